// File: rtl/cache_l1_dm_burst.sv
// rtl/cache_l1_dm_burst.sv - direct-mapped write-through L1 data cache with burst refill
module cache_l1_dm_burst #(
  parameter int ADDR_W         = 10,
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_mask,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-3:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  // Address layout: tag | line index | word in line | byte in word.
  localparam int WOFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int SET_W  = IDX_W + WOFF_W;
  localparam int TAG_W  = ADDR_W - 2 - SET_W;
  // With the default sizing the tag is empty; keep a 1-bit constant-zero tag then.
  localparam int TAG_SW = (TAG_W > 0) ? TAG_W : 1;
  localparam int CNT_W  = (WOFF_W > 0) ? WOFF_W : 1;
  localparam int WA_W   = ADDR_W - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_RESP,
    S_STORE
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_SW-1:0]  tag_q  [NUM_LINES];
  logic [31:0]        data_q [NUM_LINES*WORDS_PER_LINE];

  logic               dmem_req_q;
  logic               dmem_we_q;
  logic [WA_W-1:0]    dmem_addr_q;
  logic [31:0]        dmem_wdata_q;
  logic [3:0]         dmem_wstrb_q;

  logic [SET_W-1:0]   word_sel;
  logic [SET_W-1:0]   fill_sel;
  logic [IDX_W-1:0]   line_idx;
  logic [TAG_SW-1:0]  addr_tag;
  logic [WA_W-1:0]    word_addr;
  logic [WA_W-1:0]    line_addr;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               legal;
  logic               access;
  logic               line_match;
  logic               ack_ok;
  logic               last_beat;
  logic               fill_we;
  logic               store_we;
  logic [31:0]        cur_word;
  logic [31:0]        load_val;
  logic [31:0]        st_wdata;
  logic [3:0]         st_wstrb;
  logic [31:0]        merge_d;

  assign word_sel   = cpu_addr[SET_W+1:2];
  assign line_idx   = IDX_W'(word_sel >> WOFF_W);
  assign addr_tag   = TAG_SW'(cpu_addr >> (SET_W + 2));
  assign word_addr  = cpu_addr[ADDR_W-1:2];
  assign line_addr  = (word_addr >> WOFF_W) << WOFF_W;
  assign fill_sel   = ((word_sel >> WOFF_W) << WOFF_W) | SET_W'(cnt_q);
  assign cnt_nxt    = cnt_q + CNT_W'(1);
  assign last_beat  = (cnt_q == CNT_W'(WORDS_PER_LINE - 1));
  assign cur_word   = data_q[word_sel];

  assign legal      = (cpu_mask == 3'b000) || (cpu_mask == 3'b001) || (cpu_mask == 3'b010) ||
                      (cpu_mask == 3'b100) || (cpu_mask == 3'b101);
  assign access     = cpu_req && legal;
  assign line_match = valid_q[line_idx] && (tag_q[line_idx] == addr_tag);

  // An ack only counts while our own request is up and we are not being reset.
  assign ack_ok     = dmem_ack && dmem_req_q && !reset;
  assign fill_we    = (state_q == S_REFILL) && ack_ok;
  assign store_we   = (state_q == S_STORE) && ack_ok && line_match;

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_wstrb = dmem_wstrb_q;

  // Load result: pick the byte/half lane and extend it.
  always_comb begin
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    load_val = 32'h0;
    case (cpu_addr[1:0])
      2'd0:    byte_v = cur_word[7:0];
      2'd1:    byte_v = cur_word[15:8];
      2'd2:    byte_v = cur_word[23:16];
      default: byte_v = cur_word[31:24];
    endcase
    half_v = cpu_addr[1] ? cur_word[31:16] : cur_word[15:0];
    case (cpu_mask)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b010:  load_val = cur_word;
      3'b100:  load_val = {24'h0, byte_v};
      3'b101:  load_val = {16'h0, half_v};
      default: load_val = 32'h0;
    endcase
  end

  // Store lanes: replicate narrow data across lanes, strobe selects the real bytes.
  always_comb begin
    st_wdata = cpu_wdata;
    st_wstrb = 4'b1111;
    case (cpu_mask[1:0])
      2'b00: begin
        st_wdata = {4{cpu_wdata[7:0]}};
        st_wstrb = 4'b0001 << cpu_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{cpu_wdata[15:0]}};
        st_wstrb = cpu_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = cpu_wdata;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Store-hit merge of the strobed bytes into the cached word.
  always_comb begin
    merge_d = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (dmem_wstrb_q[b]) merge_d[8*b +: 8] = dmem_wdata_q[8*b +: 8];
    end
  end

  // Core-facing outputs: stall and load data, forced quiet while in reset.
  always_comb begin
    stall     = 1'b0;
    cpu_rdata = 32'h0;
    if (!reset) begin
      case (state_q)
        S_IDLE:   stall = access && (cpu_we || !line_match);
        S_REFILL: stall = 1'b1;
        S_RESP:   stall = 1'b0;
        S_STORE:  stall = !ack_ok;
        default:  stall = 1'b0;
      endcase
      if ((state_q == S_IDLE && access && !cpu_we && line_match) || state_q == S_RESP) begin
        cpu_rdata = load_val;
      end
    end
  end

  // Control FSM with registered memory-side request signals.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      valid_q      <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= 32'h0;
      dmem_wstrb_q <= 4'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access) begin
            if (cpu_we) begin
              state_q      <= S_STORE;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= 1'b1;
              dmem_addr_q  <= word_addr;
              dmem_wdata_q <= st_wdata;
              dmem_wstrb_q <= st_wstrb;
            end else if (!line_match) begin
              // The line is being overwritten, so it stops being valid right away.
              state_q           <= S_REFILL;
              cnt_q             <= '0;
              valid_q[line_idx] <= 1'b0;
              dmem_req_q        <= 1'b1;
              dmem_we_q         <= 1'b0;
              dmem_addr_q       <= line_addr;
            end
          end
        end
        S_REFILL: begin
          if (ack_ok) begin
            if (last_beat) begin
              state_q           <= S_RESP;
              cnt_q             <= '0;
              valid_q[line_idx] <= 1'b1;
              dmem_req_q        <= 1'b0;
              dmem_addr_q       <= '0;
            end else begin
              cnt_q       <= cnt_nxt;
              dmem_addr_q <= line_addr | WA_W'(cnt_nxt);
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        S_STORE: begin
          if (ack_ok) begin
            state_q      <= S_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= 32'h0;
            dmem_wstrb_q <= 4'h0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line storage: refill beats, tag capture on the last beat, store-hit merges.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[fill_sel] <= dmem_rdata;
      if (last_beat) tag_q[line_idx] <= addr_tag;
    end
    if (store_we) begin
      data_q[word_sel] <= merge_d;
    end
  end

endmodule

// File: tb/tb_cache_l1_dm_burst.sv
// tb/tb_cache_l1_dm_burst.sv - self-checking bench for cache_l1_dm_burst
module tb_cache_l1_dm_burst;

  localparam int ADDR_W    = 10;
  localparam int NUM_LINES = 16;
  localparam int WPL       = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_mask;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  cache_l1_dm_burst #(
    .ADDR_W(ADDR_W), .NUM_LINES(NUM_LINES), .WORDS_PER_LINE(WPL)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mask(cpu_mask), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  int   ack_wait = 0;
  logic spurious = 1'b0;
  int   n_reads = 0, n_writes = 0, beat = 0, wait_cnt = 0, wr_hold = 0, last_wr_hold = 0;
  logic [3:0]  last_wstrb = 4'h0;
  logic [31:0] last_wdata = 32'h0;
  bit          res_valid [16];
  logic [1:0]  res_tag   [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal_mask(input logic [2:0] m);
    return (m == 3'b000) || (m == 3'b001) || (m == 3'b010) || (m == 3'b100) || (m == 3'b101);
  endfunction

  // Write-through: a correct load always returns what memory holds.
  function automatic logic [31:0] model_load(input logic [9:0] a, input logic [2:0] m);
    logic [31:0] w, b, h;
    w = mem[a[9:2]];
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (m)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [9:0] a, input logic [2:0] m);
    case (m[1:0])
      2'b00:   return 4'(1 << a[1:0]);
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [2:0] m);
    case (m[1:0])
      2'b00:   return (wd & 32'hFF) * 32'h0101_0101;
      2'b01:   return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // Memory responder: acks after ack_wait idle request cycles, logs traffic.
  always @(negedge clk) begin
    if (dmem_req) begin
      wr_hold++;
      if (wait_cnt >= ack_wait) begin
        dmem_ack = 1'b1;
        wait_cnt = 0;
        if (dmem_we) begin
          n_writes++;
          last_wstrb   = dmem_wstrb;
          last_wdata   = dmem_wdata;
          last_wr_hold = wr_hold;
          chk("st_addr", 32'(dmem_addr), 32'(cpu_addr >> 2));
          chk("st_wstrb", 32'(dmem_wstrb), 32'(exp_wstrb(cpu_addr, cpu_mask)));
          chk("st_wdata", dmem_wdata, exp_wdata(cpu_wdata, cpu_mask));
          for (int k = 0; k < 4; k++) begin
            if (dmem_wstrb[k]) mem[dmem_addr][8*k +: 8] = dmem_wdata[8*k +: 8];
          end
          dmem_rdata = 32'h0;
        end else begin
          chk("refill_order", 32'(dmem_addr), 32'((cpu_addr >> 4) * WPL + beat));
          dmem_rdata = mem[dmem_addr];
          n_reads++;
          beat = (beat + 1) % WPL;
        end
        wr_hold = 0;
      end else begin
        dmem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      dmem_ack   = spurious;
      dmem_rdata = spurious ? 32'hBAD0_BAD0 : 32'h0;
      wait_cnt   = 0;
      beat       = 0;
      wr_hold    = 0;
    end
  end

  // Per-cycle compare against the behavioural model.
  logic        prev_reset = 1'b1, prev_req = 1'b0, prev_ack = 1'b0;
  logic [13:0] prev_ctl = '0;
  logic [31:0] prev_wdata = '0;
  always @(negedge clk) begin
    #2;
    if (prev_reset) chk("post_rst_req", 32'(dmem_req), 32'h0);
    if (reset) begin
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_rdata", cpu_rdata, 32'h0);
    end else begin
      if (prev_req && !prev_ack && !prev_reset) begin
        chk("hold_ctl", 32'({dmem_req, dmem_we, dmem_addr, dmem_wstrb}), 32'(prev_ctl));
        chk("hold_wdata", dmem_wdata, prev_wdata);
      end
      if (!cpu_req) begin
        chk("idle_stall", 32'(stall), 32'h0);
        chk("idle_rdata", cpu_rdata, 32'h0);
        chk("idle_dreq", 32'(dmem_req), 32'h0);
      end else if (!legal_mask(cpu_mask)) begin
        chk("illegal_stall", 32'(stall), 32'h0);
        chk("illegal_rdata", cpu_rdata, 32'h0);
      end else if (!cpu_we && !stall) begin
        chk("load_data", cpu_rdata, model_load(cpu_addr, cpu_mask));
      end
    end
    prev_reset = reset;
    prev_req   = dmem_req;
    prev_ack   = dmem_ack;
    prev_ctl   = {dmem_req, dmem_we, dmem_addr, dmem_wstrb};
    prev_wdata = dmem_wdata;
  end

  task automatic access(input logic we, input logic [2:0] m, input logic [9:0] a,
                        input logic [31:0] wd, output int cyc, output logic [31:0] rd);
    cpu_req = 1'b1; cpu_we = we; cpu_mask = m; cpu_addr = a; cpu_wdata = wd;
    cyc = 0; rd = 32'h0;
    forever begin
      @(negedge clk); #3;
      cyc++;
      if (!stall) begin
        rd = cpu_rdata;
        break;
      end
      if (cyc >= 60) begin
        chk("timeout", 32'(cyc), 32'h0);
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  // One access, with latency and traffic predicted from a residency model.
  task automatic op(input logic we, input logic [2:0] m, input logic [9:0] a,
                    input logic [31:0] wd, input string nm, output logic [31:0] rd, output int cyc);
    int  exp_cyc, exp_rd, exp_wr, idx;
    bit  hit;
    idx    = int'(a[7:4]);
    hit    = res_valid[idx] && (res_tag[idx] == a[9:8]);
    exp_rd = n_reads;
    exp_wr = n_writes;
    if (!legal_mask(m)) exp_cyc = 1;
    else if (we) begin
      exp_cyc = 2 + ack_wait;
      exp_wr++;
    end else if (hit) exp_cyc = 1;
    else begin
      exp_cyc = 2 + WPL * (ack_wait + 1);
      exp_rd += WPL;
    end
    access(we, m, a, wd, cyc, rd);
    chk({nm, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    chk({nm, "_reads"}, 32'(n_reads), 32'(exp_rd));
    chk({nm, "_writes"}, 32'(n_writes), 32'(exp_wr));
    if (legal_mask(m) && !we) begin
      res_valid[idx] = 1'b1;
      res_tag[idx]   = a[9:8];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int cyc, r0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hCAFE_0000 | i;
    mem[8'h10] = 32'h1122_3344;
    mem[8'h11] = 32'hA5A5_A5A5;
    mem[8'h12] = 32'h0;
    mem[8'h13] = 32'h0;
    for (int i = 0; i < 16; i++) begin res_valid[i] = 1'b0; res_tag[i] = 2'd0; end
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_mask = 3'b010; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #3;
    chk("reset_ctl", 32'({stall, dmem_req, dmem_we, dmem_addr, dmem_wstrb}), 32'h0);
    chk("reset_data", cpu_rdata | dmem_wdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    op(1'b0, 3'b010, 10'h040, 32'h0, "lw040", rd, cyc);
    chk("lw040_stall5", 32'(cyc - 1), 32'd5);
    chk("lw040_data", rd, 32'h1122_3344);
    op(1'b0, 3'b010, 10'h044, 32'h0, "lw044", rd, cyc);
    chk("lw044_hit", 32'(cyc), 32'd1);
    chk("lw044_data", rd, 32'hA5A5_A5A5);
    op(1'b0, 3'b000, 10'h047, 32'h0, "lb047", rd, cyc);
    chk("lb047_data", rd, 32'hFFFF_FFA5);
    op(1'b0, 3'b100, 10'h047, 32'h0, "lbu047", rd, cyc);
    chk("lbu047_data", rd, 32'h0000_00A5);
    op(1'b0, 3'b001, 10'h042, 32'h0, "lh042", rd, cyc);
    chk("lh042_data", rd, 32'h0000_1122);
    op(1'b0, 3'b101, 10'h046, 32'h0, "lhu046", rd, cyc);
    chk("lhu046_data", rd, 32'h0000_A5A5);
    op(1'b0, 3'b000, 10'h043, 32'h0, "lb043", rd, cyc);
    chk("lb043_data", rd, 32'h0000_0011);
    op(1'b0, 3'b011, 10'h040, 32'h0, "illegal", rd, cyc);
    chk("illegal_data", rd, 32'h0);

    ack_wait = 2;
    op(1'b1, 3'b000, 10'h041, 32'h0000_00EE, "sb041", rd, cyc);
    chk("sb041_wstrb", 32'(last_wstrb), 32'h2);
    chk("sb041_wdata", last_wdata, 32'hEEEE_EEEE);
    chk("sb041_hold3", 32'(last_wr_hold), 32'd3);
    ack_wait = 0;
    op(1'b0, 3'b010, 10'h040, 32'h0, "lw040b", rd, cyc);
    chk("lw040b_data", rd, 32'h1122_EE44);
    chk("lw040b_hit", 32'(cyc), 32'd1);

    op(1'b1, 3'b001, 10'h047, 32'h1234_BEEF, "sh047", rd, cyc);
    chk("sh047_wstrb", 32'(last_wstrb), 32'hC);
    chk("sh047_wdata", last_wdata, 32'hBEEF_BEEF);
    op(1'b0, 3'b010, 10'h044, 32'h0, "lw044b", rd, cyc);
    chk("lw044b_data", rd, 32'hBEEF_A5A5);

    op(1'b1, 3'b010, 10'h300, 32'hDEAD_BEEF, "sw300", rd, cyc);
    chk("sw300_wstrb", 32'(last_wstrb), 32'hF);
    op(1'b0, 3'b010, 10'h300, 32'h0, "lw300", rd, cyc);
    chk("lw300_miss", 32'(cyc), 32'd6);
    chk("lw300_data", rd, 32'hDEAD_BEEF);

    op(1'b0, 3'b010, 10'h040, 32'h0, "lw040c", rd, cyc);
    op(1'b0, 3'b010, 10'h140, 32'h0, "lw140", rd, cyc);
    chk("lw140_miss", 32'(cyc), 32'd6);
    chk("lw140_data", rd, 32'hCAFE_0050);
    op(1'b0, 3'b010, 10'h040, 32'h0, "lw040d", rd, cyc);
    chk("lw040d_miss", 32'(cyc), 32'd6);
    chk("lw040d_data", rd, 32'h1122_EE44);

    // Reset landing on the second refill beat.
    r0 = n_reads;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_mask = 3'b010; cpu_addr = 10'h0C0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #3;
      if (n_reads >= r0 + 1) break;
    end
    chk("rst_first_beat", 32'(n_reads), 32'(r0 + 1));
    @(posedge clk); #1;
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk); #3;
    chk("rst_mid_ack", 32'({dmem_req, dmem_ack}), 32'h3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) res_valid[i] = 1'b0;
    spurious = 1'b1;
    @(negedge clk); #3;
    chk("spur_stall", 32'({stall, dmem_req}), 32'h0);
    @(posedge clk); #1;
    spurious = 1'b0;
    @(negedge clk); #3;
    chk("spur_after", 32'(dmem_req), 32'h0);
    @(posedge clk); #1;
    op(1'b0, 3'b010, 10'h040, 32'h0, "lw040r", rd, cyc);
    chk("lw040r_full", 32'(cyc), 32'd6);
    chk("lw040r_data", rd, 32'h1122_EE44);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_l1_dm_burst.md
Name: cache_l1_dm_burst

Overview:
- Parametrised direct-mapped, write-through L1 data cache for the RISC-V core.
- Sits between the load/store stage and the shared data memory.
- Lines hold WORDS_PER_LINE words and are refilled by a sequential burst over a req/ack memory handshake.
- Supports RV32 byte/halfword/word loads (signed and unsigned) and stores with byte strobes; stalls the core on miss or store.

Parameters:
- ADDR_W, 10, byte-address width.
- NUM_LINES, 64, number of lines (power of 2, ≥2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  access valid this cycle; held stable by the core while stall=1.
- cpu_we  in  1  1=store, 0=load.
- cpu_mask  in  3  RV32 funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_rdata  out  32  load result, extended per mask.
- stall  out  1  core must hold its request.
- dmem_req  out  1  memory request.
- dmem_we  out  1  memory write.
- dmem_addr  out  ADDR_W-2  word address.
- dmem_wdata  out  32  write data, lane-aligned.
- dmem_wstrb  out  4  byte enables.
- dmem_ack  in  1  request completes this cycle.
- dmem_rdata  in  32  read data, valid when dmem_ack=1.

Behaviour:
- Address split: [1:0] byte, next log2(WORDS_PER_LINE) bits word, next log2(NUM_LINES) bits index, remainder tag.
- Storage per line: valid, tag, data. Hit = cpu_req & valid[index] & tag match.
- Reset: all valid cleared, FSM to IDLE, burst counter 0. Outputs are 0: stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, cpu_rdata. Reset mid-burst or mid-store aborts; dmem_req drops the next cycle, and any ack arriving during or after reset is ignored.
- FSM states: IDLE, REFILL, RESP, STORE.
- IDLE:
  - Load hit: cpu_rdata valid combinationally, stall=0, zero latency.
  - Load miss: stall=1 in the same cycle; go to REFILL with counter=0.
  - Store (hit or miss): stall=1; go to STORE.
  - Illegal mask (011, 110, 111): no access, stall=0, cpu_rdata=0.
- REFILL:
  - dmem_req=1, dmem_we=0, dmem_addr={tag, index, counter}.
  - On dmem_ack: write dmem_rdata into word[counter] and increment counter.
  - When the last word is acked: set valid and tag, go to RESP.
  - Words fill in order 0..WORDS_PER_LINE-1; no critical-word-first.
- RESP: stall=0 and cpu_rdata is driven from the now-valid line (one cycle); then return to IDLE.
  - Load-miss latency = WORDS_PER_LINE acks + 1 cycle.
- STORE:
  - dmem_req=1, dmem_we=1, dmem_addr=cpu_addr[ADDR_W-1:2].
  - dmem_wdata: sb replicates byte to all lanes; sh replicates half to both halves; sw passes the word.
  - dmem_wstrb: sb = 0001<<addr[1:0]; sh = 0011<<(2*addr[1]); sw = 1111.
  - On ack: if the line hits, merge strobed bytes into the cached word; the store-miss case does not allocate. Set stall=0 and return to IDLE.
- Alignment: sh uses addr[1] only and ignores addr[0]; sw ignores addr[1:0]. No misalignment trap.
- Load extension: lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- Handshake: dmem_req, dmem_addr, dmem_we, dmem_wdata and dmem_wstrb are stable until ack. Ack may come in the same cycle req rises (next posedge). Ack while dmem_req=0 is ignored. Only one outstanding request.
- cpu_req=0 in IDLE: no state change, stall=0, cpu_rdata=0.
- Tag compare in IDLE uses current storage, so a load immediately after a store to the same line sees the merged data.

Test Plan:
- Reset, then lw 0x040 with memory words 0x11223344, 0xA5A5A5A5, 0x0, 0x0 at word addrs 0x10..0x13, ack every cycle → stall for 5 cycles, rdata=0x11223344. Next-cycle lw 0x044 hits with stall=0, rdata=0xA5A5A5A5.
- After the fill, lb 0x047 → 0xFFFFFFA5; lbu 0x047 → 0x000000A5; lh 0x042 → 0x00001122; lhu 0x046 → 0x0000A5A5.
- sb 0x041 data 0xEE on a hit, ack delayed 3 cycles → dmem_wstrb=0010, dmem_wdata=0xEEEEEEEE held 3 cycles; then lw 0x040 → 0x1122EE44 with no refill.
- Store miss sw 0x300 data 0xDEADBEEF → one memory write with wstrb=1111; a following lw 0x300 misses and refills.
- Conflicting address: lw 0x040, then lw 0x140 (same index, different tag) → second access refills, and lw 0x040 misses again.
- Assert reset during the 2nd refill ack; deassert, then lw 0x040 → full 4-word refill; spurious ack while dmem_req=0 has no effect.
